reorder_buffer: RTL and testbench

// In-order retirement queue between decoder/issue and the architectural regfile. Allocates tagged entries at

---
 rtl/reorder_buffer_pkg.sv | 14 +
 rtl/reorder_buffer_if.sv | 53 +++++
 rtl/reorder_buffer.sv | 146 ++++++++++++++
 tb/tb_reorder_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared parameters and entry-type encodings for the reorder buffer.
// Tag 0 is reserved to mean "no pending producer", so DEPTH is one less than the tag space.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH = 4;
    localparam int DEPTH     = (1 << ROB_WIDTH) - 1;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2
    } rob_type_e;

endpackage

// File: rtl/reorder_buffer_if.sv
// Decoder, CDB, regfile, LSB and fetch-redirect signals of the reorder buffer.
// The slave modport is the ROB's view; the master modport is the surrounding pipeline's view.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic                 from_decoder_valid;
    logic [1:0]           from_decoder_type;
    logic [4:0]           from_decoder_reg_id;
    logic [31:0]          from_decoder_recover_pc;
    logic                 to_decoder_full;
    logic [ROB_WIDTH-1:0] to_decoder_rob_id;
    logic [ROB_WIDTH-1:0] from_decoder_query_id1;
    logic [ROB_WIDTH-1:0] from_decoder_query_id2;
    logic                 to_decoder_query_ready1;
    logic                 to_decoder_query_ready2;
    logic [31:0]          to_decoder_query_data1;
    logic [31:0]          to_decoder_query_data2;
    logic                 from_cdb_valid;
    logic [ROB_WIDTH-1:0] from_cdb_rob_id;
    logic [31:0]          from_cdb_data;
    logic                 from_cdb_mispredict;
    logic                 to_regfile_write_enabled;
    logic [4:0]           to_regfile_reg_id;
    logic [31:0]          to_regfile_data;
    logic [ROB_WIDTH-1:0] to_regfile_rob_id;
    logic                 to_lsb_store_commit;
    logic [ROB_WIDTH-1:0] to_lsb_store_rob_id;
    logic                 flush_output;
    logic [31:0]          to_fetch_pc;

    modport slave (
        input  from_decoder_valid, from_decoder_type, from_decoder_reg_id, from_decoder_recover_pc,
        input  from_decoder_query_id1, from_decoder_query_id2,
        input  from_cdb_valid, from_cdb_rob_id, from_cdb_data, from_cdb_mispredict,
        output to_decoder_full, to_decoder_rob_id,
        output to_decoder_query_ready1, to_decoder_query_ready2,
        output to_decoder_query_data1, to_decoder_query_data2,
        output to_regfile_write_enabled, to_regfile_reg_id, to_regfile_data, to_regfile_rob_id,
        output to_lsb_store_commit, to_lsb_store_rob_id, flush_output, to_fetch_pc
    );

    modport master (
        output from_decoder_valid, from_decoder_type, from_decoder_reg_id, from_decoder_recover_pc,
        output from_decoder_query_id1, from_decoder_query_id2,
        output from_cdb_valid, from_cdb_rob_id, from_cdb_data, from_cdb_mispredict,
        input  to_decoder_full, to_decoder_rob_id,
        input  to_decoder_query_ready1, to_decoder_query_ready2,
        input  to_decoder_query_data1, to_decoder_query_data2,
        input  to_regfile_write_enabled, to_regfile_reg_id, to_regfile_data, to_regfile_rob_id,
        input  to_lsb_store_commit, to_lsb_store_rob_id, flush_output, to_fetch_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags at dispatch, captures CDB results and commits
// at most one head entry per cycle as registered regfile/LSB/flush pulses.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    reorder_buffer_if.slave rob
);

    localparam int ENTRIES = 1 << ROB_WIDTH;
    typedef logic [ROB_WIDTH-1:0] tag_t;

    function automatic tag_t next_ptr(input tag_t p);
        return (p == tag_t'(DEPTH)) ? tag_t'(1) : p + tag_t'(1);
    endfunction

    tag_t               head, tail, count;
    logic [ENTRIES-1:0] busy, ready, ent_mispredict;
    logic [1:0]         ent_type  [ENTRIES];
    logic [4:0]         ent_reg   [ENTRIES];
    logic [31:0]        ent_value [ENTRIES];
    logic [31:0]        ent_pc    [ENTRIES];
    logic               full, do_commit, do_alloc, cdb_hit;

    // A slot committing this edge may be reallocated at the same edge, so full does not block that alloc.
    always_comb begin
        full      = (count == tag_t'(DEPTH));
        do_commit = !rob.flush_output && (count != '0) && ready[head];
        do_alloc  = !rob.flush_output && rob.from_decoder_valid && (!full || do_commit);
        cdb_hit   = !rob.flush_output && rob.from_cdb_valid && busy[rob.from_cdb_rob_id]
                    && !(do_commit && rob.from_cdb_rob_id == head);
    end

    assign rob.to_decoder_full   = full;
    assign rob.to_decoder_rob_id = tail;

    // Payload is only read behind busy/ready, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (do_alloc) begin
            ent_type[tail] <= rob.from_decoder_type;
            ent_reg[tail]  <= rob.from_decoder_reg_id;
            ent_pc[tail]   <= rob.from_decoder_recover_pc;
        end
        if (cdb_hit) begin
            ent_value[rob.from_cdb_rob_id]      <= rob.from_cdb_data;
            ent_mispredict[rob.from_cdb_rob_id] <= rob.from_cdb_mispredict;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head                         <= tag_t'(1);
            tail                         <= tag_t'(1);
            count                        <= '0;
            busy                         <= '0;
            ready                        <= '0;
            rob.to_regfile_write_enabled <= 1'b0;
            rob.to_regfile_reg_id        <= '0;
            rob.to_regfile_data          <= '0;
            rob.to_regfile_rob_id        <= '0;
            rob.to_lsb_store_commit      <= 1'b0;
            rob.to_lsb_store_rob_id      <= '0;
            rob.flush_output             <= 1'b0;
            rob.to_fetch_pc              <= '0;
        end else begin
            rob.to_regfile_write_enabled <= 1'b0;
            rob.to_regfile_reg_id        <= '0;
            rob.to_regfile_data          <= '0;
            rob.to_regfile_rob_id        <= '0;
            rob.to_lsb_store_commit      <= 1'b0;
            rob.to_lsb_store_rob_id      <= '0;
            rob.flush_output             <= 1'b0;
            rob.to_fetch_pc              <= '0;
            if (rob.flush_output) begin
                head  <= tag_t'(1);
                tail  <= tag_t'(1);
                count <= '0;
                busy  <= '0;
                ready <= '0;
            end else begin
                if (do_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= next_ptr(head);
                    if (ent_type[head] == ROB_TYPE_REG && ent_reg[head] != 5'd0) begin
                        rob.to_regfile_write_enabled <= 1'b1;
                        rob.to_regfile_reg_id        <= ent_reg[head];
                        rob.to_regfile_data          <= ent_value[head];
                        rob.to_regfile_rob_id        <= head;
                    end
                    if (ent_type[head] == ROB_TYPE_STORE) begin
                        rob.to_lsb_store_commit <= 1'b1;
                        rob.to_lsb_store_rob_id <= head;
                    end
                    if (ent_type[head] == ROB_TYPE_BRANCH && ent_mispredict[head]) begin
                        rob.flush_output <= 1'b1;
                        rob.to_fetch_pc  <= ent_pc[head];
                    end
                end
                if (cdb_hit) begin
                    ready[rob.from_cdb_rob_id] <= 1'b1;
                end
                if (do_alloc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= next_ptr(tail);
                end
                if (do_alloc && !do_commit) begin
                    count <= count + tag_t'(1);
                end else if (!do_alloc && do_commit) begin
                    count <= count - tag_t'(1);
                end
            end
        end
    end

    // Operand lookup: committed-ready value first, then same-cycle CDB bypass.
    always_comb begin
        rob.to_decoder_query_ready1 = 1'b0;
        rob.to_decoder_query_data1  = '0;
        rob.to_decoder_query_ready2 = 1'b0;
        rob.to_decoder_query_data2  = '0;
        if (rob.from_decoder_query_id1 != '0) begin
            if (busy[rob.from_decoder_query_id1] && ready[rob.from_decoder_query_id1]) begin
                rob.to_decoder_query_ready1 = 1'b1;
                rob.to_decoder_query_data1  = ent_value[rob.from_decoder_query_id1];
            end else if (rob.from_cdb_valid && busy[rob.from_decoder_query_id1]
                         && rob.from_cdb_rob_id == rob.from_decoder_query_id1) begin
                rob.to_decoder_query_ready1 = 1'b1;
                rob.to_decoder_query_data1  = rob.from_cdb_data;
            end
        end
        if (rob.from_decoder_query_id2 != '0) begin
            if (busy[rob.from_decoder_query_id2] && ready[rob.from_decoder_query_id2]) begin
                rob.to_decoder_query_ready2 = 1'b1;
                rob.to_decoder_query_data2  = ent_value[rob.from_decoder_query_id2];
            end else if (rob.from_cdb_valid && busy[rob.from_decoder_query_id2]
                         && rob.from_cdb_rob_id == rob.from_decoder_query_id2) begin
                rob.to_decoder_query_ready2 = 1'b1;
                rob.to_decoder_query_data2  = rob.from_cdb_data;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized plus directed bench for reorder_buffer with a tag-queue reference model
// and a scoreboard of expected commit pulses consumed by an independent monitor.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    reorder_buffer_if rob_bus ();

    reorder_buffer dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rob    (rob_bus)
    );

    typedef struct {
        bit          v;
        logic [1:0]  ty;
        logic [4:0]  rd;
        logic [31:0] pc;
        bit          cv;
        logic [3:0]  cid;
        logic [31:0] cd;
        bit          cm;
        logic [3:0]  q1;
        logic [3:0]  q2;
    } stim_t;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] data;
        int          tag;
        logic [31:0] pc;
        int          due;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          m_busy [16];
    bit          m_ready [16];
    bit          m_misp [16];
    logic [1:0]  m_type [16];
    logic [4:0]  m_rd [16];
    logic [31:0] m_val [16];
    logic [31:0] m_pc [16];
    int          pend [$];
    int          next_tag = 1;
    bit          flush_now = 1'b0;
    exp_t        sb [$];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] kind_bits(input int k);
        case (k)
            0:       return 32'b100;
            1:       return 32'b010;
            default: return 32'b001;
        endcase
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t alloc_stim(input logic [1:0] ty, input logic [4:0] rd, input logic [31:0] pc);
        stim_t s = idle_stim();
        s.v = 1'b1; s.ty = ty; s.rd = rd; s.pc = pc;
        return s;
    endfunction

    function automatic stim_t cdb_stim(input int id, input logic [31:0] d, input bit m);
        stim_t s = idle_stim();
        s.cv = 1'b1; s.cid = 4'(id); s.cd = d; s.cm = m;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_busy[i] = 1'b0;
            m_ready[i] = 1'b0;
        end
        pend.delete();
        next_tag = 1;
        flush_now = 1'b0;
        sb.delete();
    endtask

    // Reference model: a FIFO of tags in program order; commit retires the oldest ready tag.
    task automatic model_edge(input stim_t s);
        int   size_before;
        bit   commit;
        int   t;
        exp_t e;
        if (flush_now) begin
            for (int i = 0; i < 16; i++) begin
                m_busy[i] = 1'b0;
                m_ready[i] = 1'b0;
            end
            pend.delete();
            next_tag = 1;
            flush_now = 1'b0;
            return;
        end
        size_before = pend.size();
        commit = (size_before > 0) && m_ready[pend[0]];
        if (commit) begin
            t = pend.pop_front();
            m_busy[t] = 1'b0;
            m_ready[t] = 1'b0;
            e = '{kind: 0, rd: m_rd[t], data: m_val[t], tag: t, pc: m_pc[t], due: cyc + 1};
            if (m_type[t] == ROB_TYPE_REG && m_rd[t] != 5'd0) begin
                sb.push_back(e);
            end else if (m_type[t] == ROB_TYPE_STORE) begin
                e.kind = 1;
                sb.push_back(e);
            end else if (m_type[t] == ROB_TYPE_BRANCH && m_misp[t]) begin
                e.kind = 2;
                sb.push_back(e);
                flush_now = 1'b1;
            end
        end
        if (s.cv && m_busy[s.cid]) begin
            m_ready[s.cid] = 1'b1;
            m_val[s.cid] = s.cd;
            m_misp[s.cid] = s.cm;
        end
        if (s.v && (size_before < DEPTH || commit)) begin
            t = next_tag;
            m_busy[t] = 1'b1;
            m_ready[t] = 1'b0;
            m_type[t] = s.ty;
            m_rd[t] = s.rd;
            m_pc[t] = s.pc;
            pend.push_back(t);
            next_tag = (next_tag == DEPTH) ? 1 : next_tag + 1;
        end
    endtask

    function automatic void query_model(input int q, input stim_t s, output bit r, output logic [31:0] d);
        r = 1'b0;
        d = '0;
        if (q != 0 && m_busy[q] && m_ready[q]) begin
            r = 1'b1;
            d = m_val[q];
        end else if (q != 0 && m_busy[q] && s.cv && int'(s.cid) == q) begin
            r = 1'b1;
            d = s.cd;
        end
    endfunction

    task automatic applyStimulus(input stim_t s);
        bit          r;
        logic [31:0] d;
        @(posedge clk_in);
        #1;
        checkOutput("full", {31'd0, rob_bus.to_decoder_full}, {31'd0, pend.size() == DEPTH});
        checkOutput("rob_id", {28'd0, rob_bus.to_decoder_rob_id}, next_tag);
        rob_bus.from_decoder_valid      = s.v;
        rob_bus.from_decoder_type       = s.ty;
        rob_bus.from_decoder_reg_id     = s.rd;
        rob_bus.from_decoder_recover_pc = s.pc;
        rob_bus.from_cdb_valid          = s.cv;
        rob_bus.from_cdb_rob_id         = s.cid;
        rob_bus.from_cdb_data           = s.cd;
        rob_bus.from_cdb_mispredict     = s.cm;
        rob_bus.from_decoder_query_id1  = s.q1;
        rob_bus.from_decoder_query_id2  = s.q2;
        #1;
        query_model(int'(s.q1), s, r, d);
        checkOutput("query_ready1", {31'd0, rob_bus.to_decoder_query_ready1}, {31'd0, r});
        checkOutput("query_data1", rob_bus.to_decoder_query_data1, d);
        query_model(int'(s.q2), s, r, d);
        checkOutput("query_ready2", {31'd0, rob_bus.to_decoder_query_ready2}, {31'd0, r});
        checkOutput("query_data2", rob_bus.to_decoder_query_data2, d);
        model_edge(s);
    endtask

    task automatic doReset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        rob_bus.from_decoder_valid     = 1'b0;
        rob_bus.from_cdb_valid         = 1'b0;
        rob_bus.from_decoder_query_id1 = 4'd1;
        rob_bus.from_decoder_query_id2 = 4'd2;
        model_reset();
        #1;
        checkOutput("rst_full", {31'd0, rob_bus.to_decoder_full}, 32'd0);
        checkOutput("rst_rob_id", {28'd0, rob_bus.to_decoder_rob_id}, 32'd1);
        checkOutput("rst_pulses", {29'd0, rob_bus.to_regfile_write_enabled, rob_bus.to_lsb_store_commit,
                                   rob_bus.flush_output}, 32'd0);
        checkOutput("rst_fetch_pc", rob_bus.to_fetch_pc, 32'd0);
        checkOutput("rst_query_ready", {30'd0, rob_bus.to_decoder_query_ready1,
                                        rob_bus.to_decoder_query_ready2}, 32'd0);
        #2;
        rst_in = 1'b0;
    endtask

    // Monitor: consumes one scoreboard entry per observed commit pulse.
    always @(negedge clk_in) begin
        exp_t e;
        logic [31:0] seen;
        if (!rst_in) begin
            seen = {29'd0, rob_bus.to_regfile_write_enabled, rob_bus.to_lsb_store_commit, rob_bus.flush_output};
            if (seen != 32'd0) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", seen, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("commit_cycle", cyc, e.due);
                    checkOutput("pulse_kind", seen, kind_bits(e.kind));
                    if (e.kind == 0) begin
                        checkOutput("regfile_reg_id", {27'd0, rob_bus.to_regfile_reg_id}, {27'd0, e.rd});
                        checkOutput("regfile_data", rob_bus.to_regfile_data, e.data);
                        checkOutput("regfile_rob_id", {28'd0, rob_bus.to_regfile_rob_id}, e.tag);
                    end else if (e.kind == 1) begin
                        checkOutput("lsb_rob_id", {28'd0, rob_bus.to_lsb_store_rob_id}, e.tag);
                    end else begin
                        checkOutput("fetch_pc", rob_bus.to_fetch_pc, e.pc);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checkOutput("missing_pulse", seen, kind_bits(e.kind));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t s;
        int    cand [$];
        int    r;
        rob_bus.from_decoder_valid      = 1'b0;
        rob_bus.from_decoder_type       = '0;
        rob_bus.from_decoder_reg_id     = '0;
        rob_bus.from_decoder_recover_pc = '0;
        rob_bus.from_cdb_valid          = 1'b0;
        rob_bus.from_cdb_rob_id         = '0;
        rob_bus.from_cdb_data           = '0;
        rob_bus.from_cdb_mispredict     = 1'b0;
        rob_bus.from_decoder_query_id1  = '0;
        rob_bus.from_decoder_query_id2  = '0;
        doReset();

        // Single register result, then out-of-order results retiring in order.
        applyStimulus(alloc_stim(ROB_TYPE_REG, 5'd3, 32'h0));
        applyStimulus(cdb_stim(1, 32'h55, 1'b0));
        applyStimulus(alloc_stim(ROB_TYPE_REG, 5'd5, 32'h0));
        applyStimulus(alloc_stim(ROB_TYPE_REG, 5'd6, 32'h0));
        applyStimulus(cdb_stim(3, 32'h66, 1'b0));
        applyStimulus(cdb_stim(2, 32'h77, 1'b0));
        for (int i = 0; i < 3; i++) applyStimulus(idle_stim());

        // Query bypass on a broadcasting tag and tag 0.
        applyStimulus(alloc_stim(ROB_TYPE_REG, 5'd7, 32'h0));
        s = cdb_stim(4, 32'hAB, 1'b0);
        s.q1 = 4'd4;
        s.q2 = 4'd0;
        applyStimulus(s);
        applyStimulus(idle_stim());

        // Mispredicted branch at head with younger entries pending.
        applyStimulus(alloc_stim(ROB_TYPE_BRANCH, 5'd0, 32'h1000));
        applyStimulus(alloc_stim(ROB_TYPE_REG, 5'd8, 32'h0));
        applyStimulus(alloc_stim(ROB_TYPE_STORE, 5'd0, 32'h0));
        applyStimulus(alloc_stim(ROB_TYPE_REG, 5'd9, 32'h0));
        applyStimulus(cdb_stim(5, 32'h1, 1'b1));
        applyStimulus(idle_stim());
        applyStimulus(alloc_stim(ROB_TYPE_REG, 5'd10, 32'h0));
        for (int i = 0; i < 3; i++) applyStimulus(idle_stim());

        // Fill to full, rejected alloc, then alloc alongside a head commit.
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(alloc_stim(ROB_TYPE_STORE, 5'd0, 32'h0));
        applyStimulus(alloc_stim(ROB_TYPE_REG, 5'd1, 32'h0));
        applyStimulus(cdb_stim(1, 32'h0, 1'b0));
        applyStimulus(alloc_stim(ROB_TYPE_REG, 5'd2, 32'h0));
        for (int i = 0; i < 2; i++) applyStimulus(idle_stim());

        // Randomized traffic, then a drain phase that resolves everything pending.
        for (int n = 0; n < 2200; n++) begin
            s = idle_stim();
            s.v  = (n < 2000) && (pend.size() < DEPTH) && ($urandom_range(0, 9) < 6);
            s.ty = 2'($urandom_range(0, 2));
            s.rd = 5'($urandom);
            s.pc = $urandom;
            cand.delete();
            foreach (pend[i]) if (!m_ready[pend[i]]) cand.push_back(pend[i]);
            r = $urandom_range(0, 9);
            if ((r < 5 || n >= 2000) && cand.size() > 0) begin
                s.cv  = 1'b1;
                s.cid = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if (r == 5) begin
                s.cv  = 1'b1;
                s.cid = 4'($urandom);
            end
            s.cd = $urandom;
            s.cm = ($urandom_range(0, 3) == 0);
            s.q1 = 4'($urandom);
            s.q2 = s.cv ? s.cid : 4'($urandom);
            applyStimulus(s);
        end

        // Asynchronous reset with five entries outstanding.
        for (int i = 0; i < 5; i++) applyStimulus(alloc_stim(ROB_TYPE_REG, 5'(i + 1), 32'h0));
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(idle_stim());

        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
